// File: rtl/xor_crypt_pipe_param_pkg.sv
// crypt_pipe_pkg: shared types, default parameter values and rotate helpers
// for the parametrised XOR crypt pipe.
//   crypt_mode_t : direction of the per-word operation (encrypt / decrypt)
//   DEF_*        : default parameter values used by the pipe and key schedule
//   rotl / rotr  : rotate a word of width w (<= ROT_MAX_W) by s positions
package crypt_pipe_pkg;

    typedef enum logic {
        CRYPT_ENC = 1'b0,
        CRYPT_DEC = 1'b1
    } crypt_mode_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_KEYS = 3;
    localparam int DEF_CNT_W    = 3;
    localparam int DEF_PERM_ROT = 3;

    // Rotations are computed in a fixed-width container; words up to this
    // width are supported.
    localparam int ROT_MAX_W = 64;

    // Rotate the low w bits of x left by s; bits above w are returned as zero.
    function automatic logic [ROT_MAX_W-1:0] rotl(input logic [ROT_MAX_W-1:0] x,
                                                 input int unsigned w,
                                                 input int unsigned s);
        logic [ROT_MAX_W-1:0] mask;
        logic [ROT_MAX_W-1:0] xm;
        int unsigned          sm;
        mask = (w >= ROT_MAX_W) ? '1 : ((ROT_MAX_W'(1) << w) - ROT_MAX_W'(1));
        xm   = x & mask;
        sm   = s % w;
        if (sm == 0) begin
            return xm;
        end
        return ((xm << sm) | (xm >> (w - sm))) & mask;
    endfunction

    // Rotate right by s == rotate left by (w - s).
    function automatic logic [ROT_MAX_W-1:0] rotr(input logic [ROT_MAX_W-1:0] x,
                                                 input int unsigned w,
                                                 input int unsigned s);
        return rotl(x, w, w - (s % w));
    endfunction

endpackage

// File: rtl/xor_crypt_pipe_param_if.sv
// xor_crypt_pipe_param_if: valid/ready stream bus around the crypt pipe.
//   in_valid / in_ready / din    : upstream word handshake
//   out_valid / out_ready / dout : downstream word handshake
//   master : environment side (drives input word, accepts output word)
//   slave  : pipe side
interface xor_crypt_pipe_param_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] din;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dout;

    modport master (
        output in_valid, din, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, din, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/xor_crypt_pipe_param_key_sched.sv
// xor_key_sched: round-robin key selection for the crypt pipe.
//   clk, rst  : clock, synchronous active-high reset
//   advance   : a word is being accepted this cycle
//   key_sync  : restart the schedule (key 0, count 0) on the next cycle
//   rot_freq  : words per key minus one
//   keys      : packed keys, key i at [i*DATA_W +: DATA_W]
//   cur_key   : key for the word accepted this cycle
module xor_key_sched
    import crypt_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       advance,
    input  logic                       key_sync,
    input  logic [CNT_W-1:0]           rot_freq,
    input  logic [NUM_KEYS*DATA_W-1:0] keys,
    output logic [DATA_W-1:0]          cur_key
);

    localparam int SEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    assign cur_key = keys[int'(sel_q)*DATA_W +: DATA_W];

    // cnt is compared for equality only, so a rot_freq lowered below the
    // current count lets cnt run on and wrap before matching again.
    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (advance) begin
            if (cnt_q == rot_freq) begin
                cnt_d = '0;
                sel_d = (sel_q == SEL_W'(NUM_KEYS - 1)) ? '0 : sel_q + SEL_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Sync overrides an advance in the same cycle; the word already
        // used the pre-sync key via cur_key.
        if (key_sync) begin
            cnt_d = '0;
            sel_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

endmodule

// File: rtl/xor_crypt_pipe_param.sv
// xor_crypt_pipe_param: single-stage back-pressured XOR crypt pipe.
//   clk, rst : clock, synchronous active-high reset
//   bus      : valid/ready stream (slave side), in_ready = !out_valid || out_ready
//   keys     : NUM_KEYS packed round-robin keys, key 0 in the low bits
//   rot_freq : words per key minus one
//   mode     : 1 = decrypt rotl(din ^ k), 0 = encrypt rotr(din) ^ k
//   key_sync : one-cycle pulse restarting the key schedule
//   word_count (only with CRYPT_WORD_CNT_EN): 32-bit accepted-word counter
module xor_crypt_pipe_param
    import crypt_pipe_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int PERM_ROT = DEF_PERM_ROT
) (
    input  logic                       clk,
    input  logic                       rst,
    xor_crypt_pipe_param_if.slave      bus,
    input  logic [NUM_KEYS*DATA_W-1:0] keys,
    input  logic [CNT_W-1:0]           rot_freq,
    input  logic                       mode,
    input  logic                       key_sync
`ifdef CRYPT_WORD_CNT_EN
    ,
    output logic [31:0]                word_count
`endif
);

    logic              accept;
    logic              xfer;
    logic [DATA_W-1:0] cur_key;
    logic [DATA_W-1:0] result;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.dout      = dout_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign xfer          = valid_q && bus.out_ready;

    xor_key_sched #(
        .DATA_W   (DATA_W),
        .NUM_KEYS (NUM_KEYS),
        .CNT_W    (CNT_W)
    ) u_sched (
        .clk      (clk),
        .rst      (rst),
        .advance  (accept),
        .key_sync (key_sync),
        .rot_freq (rot_freq),
        .keys     (keys),
        .cur_key  (cur_key)
    );

    always_comb begin
        result = '0;
        case (crypt_mode_t'(mode))
            CRYPT_DEC: result = DATA_W'(rotl(ROT_MAX_W'(bus.din ^ cur_key), DATA_W, PERM_ROT));
            default:   result = DATA_W'(rotr(ROT_MAX_W'(bus.din), DATA_W, PERM_ROT)) ^ cur_key;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dout_d  = dout_q;
        if (accept) begin
            valid_d = 1'b1;
            dout_d  = result;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

`ifdef CRYPT_WORD_CNT_EN
    logic [31:0] wcnt_q;

    assign word_count = wcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else if (accept) begin
            wcnt_q <= wcnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xor_crypt_pipe_param.sv
// tb_xor_crypt_pipe_param: scoreboard bench for the XOR crypt pipe.
// Inputs change 2 ns after the rising edge; the monitor samples on the falling
// edge, where its view of the handshake is what the next rising edge consumes.
module tb_xor_crypt_pipe_param;

    localparam int ROT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] keys;
    logic [2:0]  rot_freq;
    logic        mode;
    logic        key_sync;

    always #5 clk = ~clk;

    xor_crypt_pipe_param_if #(.DATA_W(8)) bus ();
    xor_crypt_pipe_param_if #(.DATA_W(8)) lb_enc_if ();
    xor_crypt_pipe_param_if #(.DATA_W(8)) lb_dec_if ();
    xor_crypt_pipe_param_if #(.DATA_W(8)) k1_if ();

`ifdef CRYPT_WORD_CNT_EN
    logic [31:0] word_count;
    logic [31:0] lb_enc_wc, lb_dec_wc, k1_wc;
`endif

    xor_crypt_pipe_param #(.DATA_W(8), .NUM_KEYS(3), .CNT_W(3), .PERM_ROT(3)) dut (
        .clk(clk), .rst(rst), .bus(bus), .keys(keys), .rot_freq(rot_freq),
        .mode(mode), .key_sync(key_sync)
`ifdef CRYPT_WORD_CNT_EN
        , .word_count(word_count)
`endif
    );

    // Loopback: encrypt instance feeding a decrypt instance.
    xor_crypt_pipe_param #(.DATA_W(8), .NUM_KEYS(3), .CNT_W(3), .PERM_ROT(3)) u_lb_enc (
        .clk(clk), .rst(rst), .bus(lb_enc_if), .keys(keys), .rot_freq(rot_freq),
        .mode(1'b0), .key_sync(key_sync)
`ifdef CRYPT_WORD_CNT_EN
        , .word_count(lb_enc_wc)
`endif
    );

    xor_crypt_pipe_param #(.DATA_W(8), .NUM_KEYS(3), .CNT_W(3), .PERM_ROT(3)) u_lb_dec (
        .clk(clk), .rst(rst), .bus(lb_dec_if), .keys(keys), .rot_freq(rot_freq),
        .mode(1'b1), .key_sync(key_sync)
`ifdef CRYPT_WORD_CNT_EN
        , .word_count(lb_dec_wc)
`endif
    );

    assign lb_dec_if.in_valid  = lb_enc_if.out_valid;
    assign lb_dec_if.din       = lb_enc_if.dout;
    assign lb_enc_if.out_ready = lb_dec_if.in_ready;
    assign lb_dec_if.out_ready = 1'b1;

    // Single-key build shadowing every word the main instance accepts.
    xor_crypt_pipe_param #(.DATA_W(8), .NUM_KEYS(1), .CNT_W(3), .PERM_ROT(3)) u_k1 (
        .clk(clk), .rst(rst), .bus(k1_if), .keys(8'h5A), .rot_freq(rot_freq),
        .mode(mode), .key_sync(key_sync)
`ifdef CRYPT_WORD_CNT_EN
        , .word_count(k1_wc)
`endif
    );

    assign k1_if.in_valid  = bus.in_valid && bus.in_ready;
    assign k1_if.din       = bus.din;
    assign k1_if.out_ready = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] K [3] = '{8'h3C, 8'hA5, 8'h0F};
    logic [7:0] sb_q [$];
    logic [7:0] k1_q [$];
    logic [7:0] lb_q [$];
    logic [7:0] out_log [$];
    logic [2:0] m_cnt;
    int unsigned m_sel;
    int unsigned m_wc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] d, input logic m, input logic [7:0] k);
        logic [15:0] t;
        if (m) begin
            t = {d ^ k, d ^ k} << ROT;
            return t[15:8];
        end
        t = {d, d} >> ROT;
        return t[7:0] ^ k;
    endfunction

    // Scoreboard monitor
    initial begin
        m_cnt = '0;
        m_sel = 0;
        m_wc  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                k1_q.delete();
                lb_q.delete();
                m_cnt = '0;
                m_sel = 0;
                m_wc  = 0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) check("sb_unexpected_out", 32'(bus.dout), 32'hFFFF_FFFF);
                    else check("dout", 32'(bus.dout), 32'(sb_q.pop_front()));
                    out_log.push_back(bus.dout);
                end
                if (bus.in_valid && bus.in_ready) begin
                    sb_q.push_back(model(bus.din, mode, K[m_sel]));
                    k1_q.push_back(model(bus.din, mode, 8'h5A));
                    m_wc++;
                    if (m_cnt == rot_freq) begin
                        m_cnt = '0;
                        m_sel = (m_sel == 2) ? 0 : m_sel + 1;
                    end else begin
                        m_cnt = m_cnt + 3'd1;
                    end
                end
                if (key_sync) begin
                    m_cnt = '0;
                    m_sel = 0;
                end
                if (k1_if.out_valid) begin
                    if (k1_q.size() == 0) check("k1_unexpected_out", 32'(k1_if.dout), 32'hFFFF_FFFF);
                    else check("k1_dout", 32'(k1_if.dout), 32'(k1_q.pop_front()));
                end
                if (lb_enc_if.in_valid && lb_enc_if.in_ready) lb_q.push_back(lb_enc_if.din);
                if (lb_dec_if.out_valid) begin
                    if (lb_q.size() == 0) check("lb_unexpected_out", 32'(lb_dec_if.dout), 32'hFFFF_FFFF);
                    else check("loopback", 32'(lb_dec_if.dout), 32'(lb_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // Present a word and hold it until accepted (bounded); stalls reports cycles waited.
    task automatic send(input logic [7:0] d, input logic m, input logic sync, output int stalls);
        bus.in_valid = 1'b1;
        bus.din      = d;
        mode         = m;
        key_sync     = sync;
        stalls       = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            stalls++;
            if (stalls > 100) begin
                check("send_timeout", 32'(stalls), 32'd0);
                break;
            end
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        key_sync     = 1'b0;
    endtask

    task automatic lb_send(input logic [7:0] d);
        int w;
        lb_enc_if.in_valid = 1'b1;
        lb_enc_if.din      = d;
        w = 0;
        forever begin
            @(negedge clk);
            if (lb_enc_if.in_ready) break;
            w++;
            if (w > 100) begin
                check("lb_send_timeout", 32'(w), 32'd0);
                break;
            end
            @(posedge clk); #2;
        end
        @(posedge clk); #2;
        lb_enc_if.in_valid = 1'b0;
    endtask

    task automatic sync_pulse();
        key_sync = 1'b1;
        @(posedge clk); #2;
        key_sync = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_log(input string tag, input logic [7:0] exp [$]);
        check({tag, "_len"}, 32'(out_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(out_log[i]), 32'(exp[i]));
    endtask

    initial begin
        int st;
        int tot;
        logic [7:0] exp_log [$];

        rst = 1'b1; keys = {8'h0F, 8'hA5, 8'h3C}; rot_freq = 3'd1;
        mode = 1'b1; key_sync = 1'b0;
        bus.in_valid = 1'b0; bus.din = '0; bus.out_ready = 1'b1;
        lb_enc_if.in_valid = 1'b0; lb_enc_if.din = '0;
        @(posedge clk); #2;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_in_ready_after", 32'(bus.in_ready), 32'd1);
`ifdef CRYPT_WORD_CNT_EN
        check("rst_word_count", word_count, 32'd0);
`endif
        @(posedge clk); #2;

        // 1: single decrypt word, one-cycle latency, one-cycle valid pulse
        send(8'h00, 1'b1, 1'b0, st);
        @(negedge clk);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_dout", 32'(bus.dout), 32'hE1);
        @(negedge clk);
        check("t1_out_valid_drop", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #2;

        // 2: schedule k0,k0,k1,k1,k2,k2,k0 back-to-back
        sync_pulse();
        out_log.delete();
        tot = 0;
        for (int i = 0; i < 7; i++) begin
            send(8'h00, 1'b1, 1'b0, st);
            bus.in_valid = 1'b1;
            tot += st;
        end
        bus.in_valid = 1'b0;
        drain(3);
        check("t2_stalls", 32'(tot), 32'd0);
        exp_log = '{8'hE1, 8'hE1, 8'h2D, 8'h2D, 8'h78, 8'h78, 8'hE1};
        check_log("t2_keys", exp_log);

        // 3: backpressure freezes dout and the schedule
        sync_pulse();
        out_log.delete();
        send(8'h00, 1'b1, 1'b0, st);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.din       = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_in_ready", 32'(bus.in_ready), 32'd0);
            check("t3_out_valid", 32'(bus.out_valid), 32'd1);
            check("t3_dout_hold", 32'(bus.dout), 32'hE1);
            @(posedge clk); #2;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'h00, 1'b1, 1'b0, st);
        drain(3);
        exp_log = '{8'hE1, 8'hE1, 8'h2D, 8'h2D, 8'h78};
        check_log("t3_keys", exp_log);

        // mixed data and modes through the scoreboard
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, st);
            if (i % 5 == 2) begin
                bus.out_ready = 1'b0;
                drain(2);
                bus.out_ready = 1'b1;
            end
        end
        drain(3);

        // 4: key_sync on the 3rd accept
        mode = 1'b1;
        sync_pulse();
        out_log.delete();
        send(8'h00, 1'b1, 1'b0, st);
        send(8'h00, 1'b1, 1'b0, st);
        send(8'h00, 1'b1, 1'b1, st);
        send(8'h00, 1'b1, 1'b0, st);
        send(8'h00, 1'b1, 1'b0, st);
        send(8'h00, 1'b1, 1'b0, st);
        drain(3);
        exp_log = '{8'hE1, 8'hE1, 8'h2D, 8'hE1, 8'hE1, 8'h2D};
        check_log("t4_keys", exp_log);

        // 5: loopback encrypt -> decrypt, rot_freq 1 then 0
        sync_pulse();
        for (int v = 0; v < 256; v++) lb_send(8'(v));
        drain(4);
        rot_freq = 3'd0;
        sync_pulse();
        for (int v = 0; v < 256; v++) lb_send(8'(v));
        drain(4);
        check("t5_lb_drained", 32'(lb_q.size()), 32'd0);
        rot_freq = 3'd1;

        // rot_freq lowered below the current count: cnt runs on and wraps
        sync_pulse();
        rot_freq = 3'd3;
        for (int i = 0; i < 3; i++) send(8'h00, 1'b1, 1'b0, st);
        rot_freq = 3'd0;
        for (int i = 0; i < 8; i++) send(8'h00, 1'b1, 1'b0, st);
        rot_freq = 3'd1;
        drain(3);

        // 6: reset on the cycle after the 3rd accept
        sync_pulse();
        for (int i = 0; i < 3; i++) send(8'h00, 1'b1, 1'b0, st);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 32'(bus.out_valid), 32'd0);
        check("t6_dout", 32'(bus.dout), 32'd0);
`ifdef CRYPT_WORD_CNT_EN
        check("t6_word_count_rst", word_count, 32'd0);
`endif
        @(posedge clk); #2;
        out_log.delete();
        for (int i = 0; i < 5; i++) send(8'h00, 1'b1, 1'b0, st);
        drain(3);
        exp_log = '{8'hE1, 8'hE1, 8'h2D, 8'h2D, 8'h78};
        check_log("t6_keys", exp_log);
`ifdef CRYPT_WORD_CNT_EN
        check("t6_word_count", word_count, 32'd5);
        check("word_count_model", word_count, 32'(m_wc));
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("k1_drained", 32'(k1_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
